// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: ID/EX/MEM hazard sources in, stall/flush
// controls and statistics out.
interface hazard_unit_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_branch;
  logic        redirect;
  logic        ex_memread;
  logic        ex_regwrite;
  logic [4:0]  ex_rd;
  logic        mem_memread;
  logic [4:0]  mem_rd;
  logic        clr_stats;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_stall;
  logic        if_id_flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, redirect,
           ex_memread, ex_regwrite, ex_rd, mem_memread, mem_rd, clr_stats,
    input  pc_write, if_id_write, id_ex_stall, if_id_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, redirect,
           ex_memread, ex_regwrite, ex_rd, mem_memread, mem_rd, clr_stats,
    output pc_write, if_id_write, id_ex_stall, if_id_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / branch-operand hazard detection with multi-cycle hold for a load feeding an
// ID-stage branch, taken-branch squash of IF/ID, and saturating stall/flush counters.
module hazard_unit #(
  parameter int unsigned LOAD_BRANCH_STALLS = 2
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hz
);

  typedef enum logic {StRun, StHold} state_e;

  localparam logic [1:0] HoldInit = 2'(LOAD_BRANCH_STALLS - 32'd2);

  state_e      state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        ex_match, mem_match;
  logic        load_use, br_alu, br_load_mem;
  logic        stall, flush;

  function automatic logic reg_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
    return (x != 5'd0) && ((use_rs && x == rs) || (use_rt && x == rt));
  endfunction

  always_comb begin
    ex_match    = reg_match(hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_uses_rs, hz.id_uses_rt);
    mem_match   = reg_match(hz.mem_rd, hz.id_rs, hz.id_rt, hz.id_uses_rs, hz.id_uses_rt);
    load_use    = hz.ex_memread && ex_match;
    br_alu      = hz.id_is_branch && hz.ex_regwrite && !hz.ex_memread && ex_match;
    br_load_mem = hz.id_is_branch && hz.mem_memread && mem_match;
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        stall = load_use || br_alu || br_load_mem;
        // First bubble is this cycle; HOLD supplies the rest for a load feeding a branch.
        if (load_use && hz.id_is_branch) begin
          state_d = StHold;
          hcnt_d  = HoldInit;
        end
      end
      StHold: begin
        stall = 1'b1;
        if (hcnt_q == 2'd0) state_d = StRun;
        else                hcnt_d  = hcnt_q - 2'd1;
      end
    endcase
  end

  // Branch operands are not valid while stalled, so a redirect then is ignored.
  assign flush = hz.redirect && !stall;

  assign hz.pc_write    = reset && !stall;
  assign hz.if_id_write = reset && !stall;
  assign hz.id_ex_stall = reset && stall;
  assign hz.if_id_flush = reset && flush;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.clr_stats) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      hcnt_q      <= 2'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: two hazard_unit instances (2 and 3 load-branch bubbles) share stimulus
// and are checked each cycle against a bubble-count reference model.
module tb_hazard_unit;

  typedef struct {
    logic       rst;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_is_branch, redirect;
    logic       ex_memread, ex_regwrite;
    logic [4:0] ex_rd;
    logic       mem_memread;
    logic [4:0] mem_rd;
    logic       clr_stats;
  } in_t;

  typedef struct packed {
    logic        pc_write, if_id_write, id_ex_stall, if_id_flush;
    logic [15:0] stall_cnt, flush_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  in_t  cur;

  int vectors = 0;
  int miscompares = 0;

  exp_t q2[$];
  exp_t q3[$];

  // Reference state per instance: outstanding extra bubbles and counters.
  int pend[2];
  int sc[2];
  int fc[2];

  always #5 clk = ~clk;

  hazard_unit_if bus2 ();
  hazard_unit_if bus3 ();

  hazard_unit #(.LOAD_BRANCH_STALLS(2)) dut2 (.clk(clk), .reset(reset), .hz(bus2));
  hazard_unit #(.LOAD_BRANCH_STALLS(3)) dut3 (.clk(clk), .reset(reset), .hz(bus3));

  assign reset = cur.rst;
  assign bus2.id_rs        = cur.id_rs;        assign bus3.id_rs        = cur.id_rs;
  assign bus2.id_rt        = cur.id_rt;        assign bus3.id_rt        = cur.id_rt;
  assign bus2.id_uses_rs   = cur.id_uses_rs;   assign bus3.id_uses_rs   = cur.id_uses_rs;
  assign bus2.id_uses_rt   = cur.id_uses_rt;   assign bus3.id_uses_rt   = cur.id_uses_rt;
  assign bus2.id_is_branch = cur.id_is_branch; assign bus3.id_is_branch = cur.id_is_branch;
  assign bus2.redirect     = cur.redirect;     assign bus3.redirect     = cur.redirect;
  assign bus2.ex_memread   = cur.ex_memread;   assign bus3.ex_memread   = cur.ex_memread;
  assign bus2.ex_regwrite  = cur.ex_regwrite;  assign bus3.ex_regwrite  = cur.ex_regwrite;
  assign bus2.ex_rd        = cur.ex_rd;        assign bus3.ex_rd        = cur.ex_rd;
  assign bus2.mem_memread  = cur.mem_memread;  assign bus3.mem_memread  = cur.mem_memread;
  assign bus2.mem_rd       = cur.mem_rd;       assign bus3.mem_rd       = cur.mem_rd;
  assign bus2.clr_stats    = cur.clr_stats;    assign bus3.clr_stats    = cur.clr_stats;

  function automatic logic m(input logic [4:0] x, input in_t v);
    return (x != 0) && ((v.id_uses_rs && x == v.id_rs) || (v.id_uses_rt && x == v.id_rt));
  endfunction

  task automatic model(input int i, input in_t v, output exp_t e);
    int  n;
    bit  lu, hzd, stall, flush;
    n = (i == 0) ? 2 : 3;
    if (!v.rst) begin
      pend[i] = 0; sc[i] = 0; fc[i] = 0;
      e = '0;
      return;
    end
    lu  = v.ex_memread && m(v.ex_rd, v);
    hzd = lu || (v.id_is_branch && v.ex_regwrite && !v.ex_memread && m(v.ex_rd, v))
             || (v.id_is_branch && v.mem_memread && m(v.mem_rd, v));
    stall = (pend[i] > 0) || hzd;
    flush = v.redirect && !stall;
    e.pc_write    = !stall;
    e.if_id_write = !stall;
    e.id_ex_stall = stall;
    e.if_id_flush = flush;
    e.stall_cnt   = 16'(sc[i]);
    e.flush_cnt   = 16'(fc[i]);
    if (pend[i] > 0) pend[i]--;
    else if (lu && v.id_is_branch) pend[i] = n - 1;
    if (v.clr_stats) begin
      sc[i] = 0; fc[i] = 0;
    end else begin
      if (stall && sc[i] < 65535) sc[i]++;
      if (flush && fc[i] < 65535) fc[i]++;
    end
  endtask

  task automatic step(input in_t v);
    exp_t e;
    @(posedge clk);
    #1;
    cur = v;
    model(0, v, e); q2.push_back(e);
    model(1, v, e); q3.push_back(e);
  endtask

  task automatic check(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got pc=%b ifid=%b stall=%b flush=%b scnt=%h fcnt=%h, want pc=%b ifid=%b stall=%b flush=%b scnt=%h fcnt=%h",
               name, $time, act.pc_write, act.if_id_write, act.id_ex_stall, act.if_id_flush,
               act.stall_cnt, act.flush_cnt, exp.pc_write, exp.if_id_write, exp.id_ex_stall,
               exp.if_id_flush, exp.stall_cnt, exp.flush_cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("lbs2", {bus2.pc_write, bus2.if_id_write, bus2.id_ex_stall, bus2.if_id_flush,
                     bus2.stall_cnt, bus2.flush_cnt}, e);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      check("lbs3", {bus3.pc_write, bus3.if_id_write, bus3.id_ex_stall, bus3.if_id_flush,
                     bus3.stall_cnt, bus3.flush_cnt}, e);
    end
  end

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    v.rst = 1'b1;
    return v;
  endfunction

  initial begin
    in_t v;
    cur = '{default: '0};
    pend = '{0, 0}; sc = '{0, 0}; fc = '{0, 0};

    v = idle(); v.rst = 1'b0;
    step(v); step(v);
    step(idle()); step(idle());

    // Load-use, one bubble.
    v = idle(); v.ex_memread = 1; v.ex_rd = 8; v.id_uses_rs = 1; v.id_rs = 8;
    step(v); step(idle()); step(idle());

    // Load feeding a branch: 2 or 3 bubbles.
    v = idle(); v.ex_memread = 1; v.ex_rd = 9; v.id_is_branch = 1; v.id_rt = 9;
    v.id_uses_rt = 1;
    step(v); for (int i = 0; i < 4; i++) step(idle());

    // Branch on ALU result, then register 0.
    v = idle(); v.ex_regwrite = 1; v.ex_rd = 4; v.id_is_branch = 1; v.id_rs = 4;
    v.id_uses_rs = 1;
    step(v); step(idle());
    v.ex_rd = 0; v.id_rs = 0;
    step(v); step(idle());

    // Branch depending on a load in MEM.
    v = idle(); v.mem_memread = 1; v.mem_rd = 5; v.id_is_branch = 1; v.id_rs = 5;
    v.id_uses_rs = 1;
    step(v); step(idle());

    // Redirect alone, then with a load-use hazard.
    v = idle(); v.redirect = 1;
    step(v); step(idle());
    v.ex_memread = 1; v.ex_rd = 8; v.id_uses_rs = 1; v.id_rs = 8;
    step(v); step(idle()); step(idle());

    // Reset in the second stall cycle of a load-branch hold.
    v = idle(); v.ex_memread = 1; v.ex_rd = 9; v.id_is_branch = 1; v.id_rt = 9;
    v.id_uses_rt = 1;
    step(v);
    v = idle(); v.rst = 1'b0;
    step(v);
    step(idle()); step(idle()); step(idle());

    for (int i = 0; i < 3000; i++) begin
      v.rst          = ($urandom_range(0, 63) != 0);
      v.id_rs        = 5'($urandom_range(0, 3));
      v.id_rt        = 5'($urandom_range(0, 3));
      v.id_uses_rs   = 1'($urandom);
      v.id_uses_rt   = 1'($urandom);
      v.id_is_branch = 1'($urandom);
      v.redirect     = ($urandom_range(0, 3) == 0);
      v.ex_memread   = 1'($urandom);
      v.ex_regwrite  = 1'($urandom);
      v.ex_rd        = 5'($urandom_range(0, 3));
      v.mem_memread  = 1'($urandom);
      v.mem_rd       = 5'($urandom_range(0, 3));
      v.clr_stats    = ($urandom_range(0, 31) == 0);
      step(v);
    end

    // Saturation of the stall counter, then clear during a stall.
    v = idle(); v.clr_stats = 1;
    step(v);
    v = idle(); v.ex_memread = 1; v.ex_rd = 8; v.id_uses_rs = 1; v.id_rs = 8;
    for (int i = 0; i < 65540; i++) step(v);
    v.clr_stats = 1;
    step(v);
    step(idle()); step(idle());

    @(posedge clk);
    @(posedge clk);
    vectors++;
    if (q2.size() != 0 || q3.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending entries, want 0/0", q2.size(), q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
